// File: rtl/data_mem_initiator.sv
// Load/store initiator between the MAccess pipeline stage and a word-addressed 32-bit data RAM.
// Sub-word stores use read-modify-write; miss cycles are retried until a per-access timeout.
//
// state  | meaning
// IDLE   | ready for a request; misaligned requests are answered from here
// ACCESS | single RAM access: word store or any load
// RMW_RD | read of the word to be partially overwritten
// RMW_WR | write-back of the merged word
module data_mem_initiator #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [17:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [15:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_rw,
  output logic        mem_en,
  input  logic [31:0] mem_data_out,
  input  logic        mem_miss
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RMW_RD = 2'd2,
    RMW_WR = 2'd3
  } state_t;

  localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_rw;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [15:0] r_waddr;
  logic [1:0]  r_off;
  logic [31:0] r_wdata;
  logic [31:0] r_merged;
  logic [15:0] r_miss_cnt;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_rdata;

  logic        w_misaligned;
  logic        w_timeout;
  logic        w_accept;
  logic        w_bad_req;
  logic        w_done;
  logic        w_abort;
  logic        w_load_cap;
  logic        w_merge_cap;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [4:0]  w_shamt;
  logic [31:0] w_mask;
  logic [31:0] w_merged;

  // Reserved size 2'b11 is rejected together with misaligned requests.
  always_comb begin
    w_misaligned = 1'b0;
    case (req_size)
      2'b00:   w_misaligned = 1'b0;
      2'b01:   w_misaligned = req_addr[0];
      2'b10:   w_misaligned = |req_addr[1:0];
      default: w_misaligned = 1'b1;
    endcase
  end

  always_comb begin
    w_byte = mem_data_out[7:0];
    case (r_off)
      2'd0:    w_byte = mem_data_out[7:0];
      2'd1:    w_byte = mem_data_out[15:8];
      2'd2:    w_byte = mem_data_out[23:16];
      default: w_byte = mem_data_out[31:24];
    endcase
    w_half = r_off[1] ? mem_data_out[31:16] : mem_data_out[15:0];
    case (r_size)
      2'b00:   w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load_data = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load_data = mem_data_out;
    endcase
  end

  assign w_shamt  = {r_off, 3'b000};
  assign w_mask   = (r_size == 2'b00) ? (32'h0000_00FF << w_shamt) : (32'h0000_FFFF << w_shamt);
  assign w_merged = (mem_data_out & ~w_mask) | ((r_wdata << w_shamt) & w_mask);

  assign w_timeout = mem_miss && (r_miss_cnt == TIMEOUT_M1);

  always_comb begin
    w_next      = r_state;
    mem_en      = 1'b0;
    mem_rw      = 1'b0;
    mem_data_in = 32'h0;
    w_accept    = 1'b0;
    w_bad_req   = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    w_load_cap  = 1'b0;
    w_merge_cap = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (w_misaligned)
            w_bad_req = 1'b1;
          else if (req_rw && (req_size != 2'b10))
            w_next = RMW_RD;
          else
            w_next = ACCESS;
        end
      end
      ACCESS: begin
        mem_en = 1'b1;
        mem_rw = r_rw;
        if (r_rw)
          mem_data_in = r_wdata;
        if (mem_miss) begin
          if (w_timeout) begin
            w_abort = 1'b1;
            w_next  = IDLE;
          end
        end else begin
          w_done     = 1'b1;
          w_load_cap = ~r_rw;
          w_next     = IDLE;
        end
      end
      RMW_RD: begin
        mem_en = 1'b1;
        if (mem_miss) begin
          if (w_timeout) begin
            w_abort = 1'b1;
            w_next  = IDLE;
          end
        end else begin
          w_merge_cap = 1'b1;
          w_next      = RMW_WR;
        end
      end
      RMW_WR: begin
        mem_en      = 1'b1;
        mem_rw      = 1'b1;
        mem_data_in = r_merged;
        if (mem_miss) begin
          if (w_timeout) begin
            w_abort = 1'b1;
            w_next  = IDLE;
          end
        end else begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state      <= IDLE;
      r_rw         <= 1'b0;
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_waddr      <= 16'h0;
      r_off        <= 2'b00;
      r_wdata      <= 32'h0;
      r_merged     <= 32'h0;
      r_miss_cnt   <= 16'h0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_rdata      <= 32'h0;
    end else begin
      r_state      <= w_next;
      r_resp_valid <= w_done | w_abort | w_bad_req;
      r_resp_err   <= w_abort | w_bad_req;
      if (w_accept) begin
        r_rw     <= req_rw;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_waddr  <= req_addr[17:2];
        r_off    <= req_addr[1:0];
        r_wdata  <= req_wdata;
      end
      if (w_load_cap)
        r_rdata <= w_load_data;
      if (w_merge_cap)
        r_merged <= w_merged;
      // Each memory phase gets its own full miss budget.
      if (w_next != r_state)
        r_miss_cnt <= 16'h0;
      else if (mem_en && mem_miss)
        r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  assign req_ready   = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign resp_valid  = r_resp_valid;
  assign resp_err    = r_resp_err;
  assign rdata       = r_rdata;
  assign mem_address = r_waddr;

endmodule

// File: tb/tb_data_mem_initiator.sv
// Directed bench for data_mem_initiator with a small RAM model and scripted miss injection.
// TIMEOUT is set to 4 so both the survivable 3-miss case and the timeout case are reachable.
module tb_data_mem_initiator;

  logic        Clk;
  logic        Rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [17:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] rdata;
  logic        busy;
  logic [15:0] mem_address;
  logic [31:0] mem_data_in;
  logic        mem_rw;
  logic        mem_en;
  logic [31:0] mem_data_out;
  logic        mem_miss;

  logic [31:0] mem [0:63];
  int n_pass = 0;
  int n_total = 0;
  int en_cnt = 0;
  int wr_cnt = 0;
  int resp_cnt = 0;
  int miss_used = 0;
  int miss_req = 0;

  logic [15:0] c1_addr;
  logic        c1_en;
  logic        c1_rw;
  logic [31:0] c1_din;

  data_mem_initiator #(.TIMEOUT(4)) dut (
    .Clk(Clk), .Rst(Rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .rdata(rdata), .busy(busy), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_rw(mem_rw), .mem_en(mem_en),
    .mem_data_out(mem_data_out), .mem_miss(mem_miss)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign mem_data_out = mem[mem_address[5:0]];
  assign mem_miss     = mem_en && (miss_used < miss_req);

  always @(posedge Clk) begin
    if (mem_en && mem_rw && !mem_miss)
      mem[mem_address[5:0]] <= mem_data_in;
    if (mem_en) en_cnt <= en_cnt + 1;
    if (mem_en && mem_rw && !mem_miss) wr_cnt <= wr_cnt + 1;
    if (resp_valid) resp_cnt <= resp_cnt + 1;
    if (mem_miss) miss_used <= miss_used + 1;
  end

  // Called just after a negedge with the DUT idle; returns just after the negedge where
  // resp_valid is seen. lat counts cycles after the acceptance edge (30 = no response).
  task automatic do_req(input logic rw, input logic [1:0] size, input logic sgn,
                        input logic [17:0] addr, input logic [31:0] wd,
                        output int lat, output logic err);
    req_rw = rw; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(negedge Clk);
    req_valid = 1'b0;
    req_addr = 18'h3FFFF; req_wdata = 32'hFFFF_FFFF;
    lat = 1;
    c1_addr = mem_address; c1_en = mem_en; c1_rw = mem_rw; c1_din = mem_data_in;
    while (!resp_valid && lat < 30) begin
      @(negedge Clk);
      lat++;
    end
    err = resp_err;
  endtask

  task automatic test_reset;
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    n_total++; if (req_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", req_ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b want 0", resp_valid); else n_pass++;
    n_total++; if (resp_err !== 1'b0) $display("FAIL rst_resp_err: got %b want 0", resp_err); else n_pass++;
    n_total++; if (rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", rdata); else n_pass++;
    n_total++; if (mem_en !== 1'b0 || mem_rw !== 1'b0) $display("FAIL rst_mem_ctl: got en=%b rw=%b want 0 0", mem_en, mem_rw); else n_pass++;
    n_total++; if (mem_address !== 16'h0) $display("FAIL rst_mem_addr: got %h want 0", mem_address); else n_pass++;
    n_total++; if (mem_data_in !== 32'h0) $display("FAIL rst_mem_din: got %h want 0", mem_data_in); else n_pass++;
    Rst = 1'b0;
  endtask

  task automatic test_word;
    int lat; logic err;
    do_req(1'b1, 2'b10, 1'b0, 18'h00010, 32'hDEADBEEF, lat, err);
    n_total++; if (c1_addr !== 16'h0004 || c1_en !== 1'b1 || c1_rw !== 1'b1 || c1_din !== 32'hDEADBEEF)
      $display("FAIL wst_port: got a=%h en=%b rw=%b d=%h want 0004 1 1 deadbeef", c1_addr, c1_en, c1_rw, c1_din);
    else n_pass++;
    n_total++; if (lat !== 2 || err !== 1'b0) $display("FAIL wst_resp: got lat=%0d err=%b want 2 0", lat, err); else n_pass++;
    n_total++; if (mem[4] !== 32'hDEADBEEF) $display("FAIL wst_mem: got %h want deadbeef", mem[4]); else n_pass++;
    do_req(1'b0, 2'b10, 1'b0, 18'h00010, 32'h0, lat, err);
    n_total++; if (c1_addr !== 16'h0004 || c1_rw !== 1'b0) $display("FAIL wld_port: got a=%h rw=%b want 0004 0", c1_addr, c1_rw); else n_pass++;
    n_total++; if (lat !== 2 || err !== 1'b0) $display("FAIL wld_resp: got lat=%0d err=%b want 2 0", lat, err); else n_pass++;
    n_total++; if (rdata !== 32'hDEADBEEF) $display("FAIL wld_data: got %h want deadbeef", rdata); else n_pass++;
  endtask

  task automatic test_subword;
    int lat; logic err; int w0;
    do_req(1'b1, 2'b10, 1'b0, 18'h00010, 32'h11223344, lat, err);
    w0 = wr_cnt;
    do_req(1'b1, 2'b00, 1'b0, 18'h00011, 32'hFFFF_FFA5, lat, err);
    n_total++; if (lat !== 3 || err !== 1'b0) $display("FAIL bst_resp: got lat=%0d err=%b want 3 0", lat, err); else n_pass++;
    n_total++; if (mem[4] !== 32'h1122A544 || wr_cnt - w0 !== 1) $display("FAIL bst_mem: got %h writes=%0d want 1122a544 1", mem[4], wr_cnt - w0); else n_pass++;
    do_req(1'b0, 2'b00, 1'b1, 18'h00011, 32'h0, lat, err);
    n_total++; if (rdata !== 32'hFFFFFFA5 || lat !== 2) $display("FAIL bld_signed: got %h lat=%0d want ffffffa5 2", rdata, lat); else n_pass++;
    do_req(1'b0, 2'b00, 1'b0, 18'h00011, 32'h0, lat, err);
    n_total++; if (rdata !== 32'h000000A5) $display("FAIL bld_unsigned: got %h want 000000a5", rdata); else n_pass++;
    do_req(1'b1, 2'b01, 1'b0, 18'h00012, 32'h0000BEEF, lat, err);
    n_total++; if (mem[4] !== 32'hBEEFA544 || lat !== 3) $display("FAIL hst_mem: got %h lat=%0d want beefa544 3", mem[4], lat); else n_pass++;
    do_req(1'b0, 2'b01, 1'b1, 18'h00012, 32'h0, lat, err);
    n_total++; if (rdata !== 32'hFFFFBEEF) $display("FAIL hld_signed: got %h want ffffbeef", rdata); else n_pass++;
    do_req(1'b0, 2'b00, 1'b0, 18'h00010, 32'h0, lat, err);
    n_total++; if (rdata !== 32'h00000044) $display("FAIL bld_off0: got %h want 00000044", rdata); else n_pass++;
    do_req(1'b0, 2'b00, 1'b1, 18'h00013, 32'h0, lat, err);
    n_total++; if (rdata !== 32'hFFFFFFBE) $display("FAIL bld_off3: got %h want ffffffbe", rdata); else n_pass++;
    do_req(1'b0, 2'b01, 1'b0, 18'h00010, 32'h0, lat, err);
    n_total++; if (rdata !== 32'h0000A544) $display("FAIL hld_unsigned: got %h want 0000a544", rdata); else n_pass++;
  endtask

  task automatic test_misaligned;
    int lat; logic err; int e0;
    logic [1:0]  sizes [3] = '{2'b01, 2'b10, 2'b11};
    logic [17:0] addrs [3] = '{18'h00011, 18'h00012, 18'h00010};
    for (int i = 0; i < 3; i++) begin
      e0 = en_cnt;
      do_req(1'b0, sizes[i], 1'b0, addrs[i], 32'h0, lat, err);
      n_total++; if (lat !== 1 || err !== 1'b1 || en_cnt - e0 !== 0 || rdata !== 32'h0000A544)
        $display("FAIL misaligned_%0d: got lat=%0d err=%b en=%0d rdata=%h want 1 1 0 0000a544", i, lat, err, en_cnt - e0, rdata);
      else n_pass++;
    end
  endtask

  task automatic test_miss;
    int lat; logic err; int e0;
    e0 = en_cnt;
    miss_req = miss_used + 3;
    do_req(1'b0, 2'b10, 1'b0, 18'h00010, 32'h0, lat, err);
    n_total++; if (lat !== 5 || err !== 1'b0 || en_cnt - e0 !== 4)
      $display("FAIL miss_load_timing: got lat=%0d err=%b en=%0d want 5 0 4", lat, err, en_cnt - e0);
    else n_pass++;
    n_total++; if (rdata !== 32'hBEEFA544) $display("FAIL miss_load_data: got %h want beefa544", rdata); else n_pass++;
    miss_req = miss_used + 3;
    do_req(1'b1, 2'b00, 1'b0, 18'h00010, 32'h00000077, lat, err);
    n_total++; if (lat !== 6 || err !== 1'b0 || mem[4] !== 32'hBEEFA577)
      $display("FAIL miss_rmw: got lat=%0d err=%b mem=%h want 6 0 beefa577", lat, err, mem[4]);
    else n_pass++;
  endtask

  task automatic test_timeout;
    int lat; logic err; int w0; int m0;
    w0 = wr_cnt;
    m0 = miss_used;
    miss_req = miss_used + 1000;
    do_req(1'b1, 2'b10, 1'b0, 18'h00010, 32'h12345678, lat, err);
    n_total++; if (lat !== 5 || err !== 1'b1 || miss_used - m0 !== 4)
      $display("FAIL timeout_resp: got lat=%0d err=%b misses=%0d want 5 1 4", lat, err, miss_used - m0);
    else n_pass++;
    n_total++; if (wr_cnt - w0 !== 0 || mem[4] !== 32'hBEEFA577 || rdata !== 32'hBEEFA544)
      $display("FAIL timeout_nowrite: got writes=%0d mem=%h rdata=%h want 0 beefa577 beefa544", wr_cnt - w0, mem[4], rdata);
    else n_pass++;
    @(negedge Clk);
    n_total++; if (busy !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0)
      $display("FAIL timeout_idle: got busy=%b ready=%b rv=%b want 0 1 0", busy, req_ready, resp_valid);
    else n_pass++;
    miss_req = miss_used;
  endtask

  task automatic test_reset_mid;
    int r0; int w0;
    r0 = resp_cnt; w0 = wr_cnt;
    req_rw = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 18'h00011; req_wdata = 32'h5A;
    req_valid = 1'b1;
    @(negedge Clk);
    req_valid = 1'b0;
    n_total++; if (busy !== 1'b1 || mem_en !== 1'b1 || mem_rw !== 1'b0)
      $display("FAIL rstmid_rd: got busy=%b en=%b rw=%b want 1 1 0", busy, mem_en, mem_rw);
    else n_pass++;
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    n_total++; if (busy !== 1'b0 || req_ready !== 1'b1 || mem_en !== 1'b0 || mem_rw !== 1'b0)
      $display("FAIL rstmid_ctl: got busy=%b ready=%b en=%b rw=%b want 0 1 0 0", busy, req_ready, mem_en, mem_rw);
    else n_pass++;
    n_total++; if (mem_address !== 16'h0 || mem_data_in !== 32'h0 || rdata !== 32'h0 || resp_err !== 1'b0)
      $display("FAIL rstmid_regs: got a=%h d=%h rdata=%h err=%b want 0 0 0 0", mem_address, mem_data_in, rdata, resp_err);
    else n_pass++;
    repeat (3) @(negedge Clk);
    n_total++; if (resp_cnt - r0 !== 0 || wr_cnt - w0 !== 0 || mem[4] !== 32'hBEEFA577)
      $display("FAIL rstmid_abort: got resps=%0d writes=%0d mem=%h want 0 0 beefa577", resp_cnt - r0, wr_cnt - w0, mem[4]);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [5:0] vec;
    vec = '0;
    req_rw = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 18'h00010; req_wdata = 32'h0;
    req_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge Clk);
      vec[i-1] = resp_valid;
      if (i == 4) req_valid = 1'b0;
    end
    n_total++; if (vec !== 6'b001010) $display("FAIL b2b_pattern: got %b want 001010", vec); else n_pass++;
    n_total++; if (rdata !== 32'hBEEFA577) $display("FAIL b2b_data: got %h want beefa577", rdata); else n_pass++;
  endtask

  initial begin
    Rst = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 18'h0; req_wdata = 32'h0;
    test_reset;
    @(negedge Clk);
    test_word;
    test_subword;
    test_misaligned;
    test_miss;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/data_mem_initiator.md
# data_mem_initiator

Load/store initiator for the MAccess stage. Accepts one byte, halfword or word request at a time from the pipeline and drives the word-addressed 32-bit data RAM port (address/data_in/rw/en/data_out/miss). Sub-word stores use read-modify-write; sub-word loads are extracted and extended. It retries while `miss` is high, with a timeout, and returns one response per request.

## Interface
- `TIMEOUT`, 255: maximum consecutive miss cycles on one memory access before aborting (1..65535).
- `Clk` input 1: clock; all state changes on rising edge.
- `Rst` input 1: reset; synchronous, active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: high only in IDLE; a request is accepted on an edge where `req_valid & req_ready`.
- `req_rw` input 1: 1 = store, 0 = load.
- `req_size` input 2: 00 byte, 01 halfword, 10 word, 11 reserved (treated as misaligned).
- `req_signed` input 1: sign-extend sub-word loads when 1, zero-extend when 0.
- `req_addr` input 18: byte address; word address = `[17:2]`, byte offset = `[1:0]`.
- `req_wdata` input 32: store data, right-aligned (byte in `[7:0]`, halfword in `[15:0]`).
- `resp_valid` output 1: one-cycle pulse, one per accepted request.
- `resp_err` output 1: valid with `resp_valid`; misaligned/reserved request or timeout.
- `rdata` output 32: load result, registered; holds until the next successful load.
- `busy` output 1: `state != IDLE`.
- `mem_address` output 16, `mem_data_in` output 32, `mem_rw` output 1, `mem_en` output 1: to RAM.
- `mem_data_out` input 32, `mem_miss` input 1: from RAM. Read data is combinational in the same cycle as `mem_en & ~mem_rw`.

## Operation
- Little-endian: offset 0 is `[7:0]`. Halfword offsets 0 and 2 are legal. A word must have offset 0.
- States:
  - IDLE:
    - Misaligned or reserved request: no memory access; next cycle `resp_valid = resp_err = 1`; stay IDLE.
    - Word store, or any load: go to ACCESS.
    - Sub-word store: go to RMW_RD.
    - The request is latched into internal registers on acceptance.
  - ACCESS:
    - `mem_en = 1`, `mem_rw = latched rw`.
    - Store: `mem_data_in = wdata`.
    - If `mem_miss`: stay and increment the miss counter.
    - Else, on a load, register the extracted and extended data into `rdata`. Pulse `resp_valid` and go to IDLE.
  - RMW_RD:
    - `mem_en = 1`, `mem_rw = 0`.
    - If `mem_miss`: stay.
    - Else latch `mem_data_out` with the addressed byte/halfword replaced by the store data. Go to RMW_WR.
  - RMW_WR:
    - `mem_en = 1`, `mem_rw = 1`, `mem_data_in = merged word`.
    - If `mem_miss`: stay.
    - Else pulse `resp_valid` and go to IDLE.
- Miss counter:
  - 16-bit; cleared on every state transition.
  - When a miss occurs with the counter equal to `TIMEOUT - 1`: abort to IDLE with `resp_valid = resp_err = 1`. No write is issued and `rdata` is unchanged.
- `mem_address` is the latched word address in all states. `mem_en = 0` and `mem_rw = 0` in IDLE.
- Memory-side outputs are combinational from state and latched request only; no combinational path from `req_*`.

## Timing
- E0 is the acceptance edge.
- Load (no miss): ACCESS in the cycle after E0. `rdata` is updated at E1. `resp_valid` is high in the cycle after E1. Latency is 2 cycles.
- Word store: the RAM write occurs at E1. `resp_valid` is high in the cycle after E1.
- Sub-word store: read at E1, write at E2. `resp_valid` is high in the cycle after E2.
- Each miss cycle adds one cycle. `req_ready` stays low throughout.
- `req_ready` returns high in the same cycle `resp_valid` pulses, so back-to-back requests are accepted every 2 cycles (loads / word stores).
- Reset values: state IDLE, `req_ready = 1`, `busy = 0`, `resp_valid = 0`, `resp_err = 0`, `rdata = 0`, `mem_en = 0`, `mem_rw = 0`, `mem_address = 0`, `mem_data_in = 0`, miss counter 0.
- `Rst` asserted mid-operation: abort at that edge. A write is issued only if its RAM edge coincided with a non-reset cycle; RMW_RD reset means no write. No `resp_valid` is produced for the aborted request.
- `req_valid` while busy is ignored (not latched).

## Test plan
- Word store 0xDEADBEEF to addr 0x00010, then word load from addr 0x00010: `mem_address = 0x0004`. Load `resp_valid` occurs 2 cycles after acceptance with `rdata = 0xDEADBEEF`, `resp_err = 0`.
- Byte store 0xA5 at addr 0x00011 over word 0x11223344: RMW read then write of 0x1122A544. Signed byte load at 0x00011 gives `rdata = 0xFFFFFFA5`; unsigned gives 0x000000A5.
- Halfword load at offset 1, and word load at offset 2: no `mem_en`, `resp_err = 1` one cycle after acceptance, `rdata` unchanged.
- `mem_miss` held 3 cycles during a word load: ACCESS lasts 4 cycles, `resp_valid` arrives 5 cycles after acceptance, data correct.
- `TIMEOUT = 4`, `mem_miss` stuck high on a store: `resp_err` pulses after exactly 4 miss cycles, `mem_rw = 1` never completes, returns to IDLE.
- `Rst` pulsed during RMW_RD of a byte store: next cycle IDLE, all outputs at reset values, memory word unmodified, no `resp_valid`.
